// File: rtl/router_pkg.sv
// Shared definitions for the router output FIFOs: default sizes, header byte fields, stored entry type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package router_pkg;

   localparam int DATA_W   = 8;
   localparam int DEPTH    = 16;

   // Header byte layout: {len[DATA_W-1:2], addr[1:0]}
   localparam int ADDR_LSB = 0;
   localparam int ADDR_W   = 2;
   localparam int LEN_LSB  = 2;

   // One stored FIFO entry at the default byte width
   typedef struct packed {
      logic              hdr_flag;
      logic [DATA_W-1:0] dat;
   } entry_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage array for the router FIFO: one write port, one read port.
// Latency: write lands on the clock edge; read data is combinational from the address.
// Backpressure: none; the caller decides when a write is legal.
module router_fifo_mem
   import router_pkg::*;
#(
   parameter int WIDTH = router_pkg::DATA_W + 1,
   parameter int DEPTH = router_pkg::DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Store the incoming entry when the FIFO accepts a write
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Output-side packet FIFO for one router destination; tags header bytes and flags the last byte of each packet on read.
// Latency: one cycle from re to registered dout; full/empty are combinational from the pointers.
// Backpressure: writes while full and reads while empty are dropped; soft_rst flushes. Optional ROUTER_FIFO_ERR_FLAG_EN adds a sticky err output.
module router_fifo
   import router_pkg::*;
#(
   parameter int DATA_W = router_pkg::DATA_W,
   parameter int DEPTH  = router_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_rst,
   input  logic              we,
   input  logic              re,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              rd_pkt_done
`ifdef ROUTER_FIFO_ERR_FLAG_EN
   ,
   output logic              err
`endif
);

   localparam int PTR_W  = $clog2(DEPTH) + 1;
   localparam int AW     = PTR_W - 1;
   localparam int PCNT_W = DATA_W - 1;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PCNT_W-1:0] pkt_cnt;
   logic [PCNT_W-1:0] len_p1;
   logic [DATA_W:0]   rd_ent;
   logic              wr_fire;
   logic              rd_fire;
   logic              flush;

   // Hard reset and the synchronizer timeout clear the same state
   assign flush   = !rst || soft_rst;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign wr_fire = we && !full && !flush;
   assign rd_fire = re && !empty;

   // Header length plus the trailing parity byte
   assign len_p1  = {1'b0, rd_ent[DATA_W-1:LEN_LSB]} + {{(PCNT_W-1){1'b0}}, 1'b1};

   router_fifo_mem #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({lfd_state, din}),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_ent)
   );

   // Advance the pointers on accepted writes and reads; wrap bit toggles naturally
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Register read data and track remaining bytes of the packet being read out
   always_ff @(posedge clk) begin
      if (flush) begin
         dout        <= '0;
         pkt_cnt     <= '0;
         rd_pkt_done <= 1'b0;
      end else begin
         rd_pkt_done <= 1'b0;
         if (rd_fire) begin
            dout <= rd_ent[DATA_W-1:0];
            if (rd_ent[DATA_W]) begin
               pkt_cnt <= len_p1;
            end else if (pkt_cnt != '0) begin
               pkt_cnt     <= pkt_cnt - PCNT_W'(1);
               rd_pkt_done <= (pkt_cnt == PCNT_W'(1));
            end
         end
      end
   end

`ifdef ROUTER_FIFO_ERR_FLAG_EN
   // Sticky record of any overflow or underflow attempt since the last flush
   always_ff @(posedge clk) begin
      if (flush) begin
         err <= 1'b0;
      end else if ((we && full) || (re && empty)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed vector table, hand sequences and random traffic vs a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the model drops writes at 16 entries and reads at 0 entries.
module tb_router_fifo;
   import router_pkg::*;

   logic       clk;
   logic       rst;
   logic       soft_rst;
   logic       we;
   logic       re;
   logic       lfd_state;
   logic [7:0] din;
   logic [7:0] dout;
   logic       full;
   logic       empty;
   logic       rd_pkt_done;
`ifdef ROUTER_FIFO_ERR_FLAG_EN
   logic       err;
`endif

   router_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .soft_rst    (soft_rst),
      .we          (we),
      .re          (re),
      .lfd_state   (lfd_state),
      .din         (din),
      .dout        (dout),
      .full        (full),
      .empty       (empty),
      .rd_pkt_done (rd_pkt_done)
`ifdef ROUTER_FIFO_ERR_FLAG_EN
      ,
      .err         (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: a queue of stored entries plus the bytes left in the current packet
   entry_t     mq[$];
   bit [7:0]   m_dout;
   bit         m_done;
   int         m_rem;
   bit         m_err;
   bit         saw_ff;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_step(input bit r, input bit s, input bit w, input bit rd,
                             input bit l, input bit [7:0] d);
      bit     can_rd;
      bit     can_wr;
      entry_t e;
      entry_t ne;
      if (!r || s) begin
         mq.delete();
         m_dout = 8'h00;
         m_done = 1'b0;
         m_rem  = 0;
         m_err  = 1'b0;
      end else begin
         can_rd = rd && (mq.size() > 0);
         can_wr = w && (mq.size() < 16);
         if ((w && mq.size() == 16) || (rd && mq.size() == 0)) m_err = 1'b1;
         m_done = 1'b0;
         if (can_rd) begin
            e      = mq.pop_front();
            m_dout = e.dat;
            if (e.hdr_flag) begin
               m_rem = int'(e.dat) / 4 + 1;
            end else if (m_rem > 0) begin
               m_rem  = m_rem - 1;
               m_done = (m_rem == 0);
            end
         end
         if (can_wr) begin
            ne.hdr_flag = l;
            ne.dat      = d;
            mq.push_back(ne);
         end
      end
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".dout"},  int'(dout),        int'(m_dout));
      chk({tag, ".empty"}, int'(empty),       int'(mq.size() == 0));
      chk({tag, ".full"},  int'(full),        int'(mq.size() == 16));
      chk({tag, ".done"},  int'(rd_pkt_done), int'(m_done));
`ifdef ROUTER_FIFO_ERR_FLAG_EN
      chk({tag, ".err"},   int'(err),         int'(m_err));
`endif
      if (dout == 8'hFF) saw_ff = 1'b1;
   endtask

   task automatic cyc(input bit r, input bit s, input bit w, input bit rd,
                      input bit l, input bit [7:0] d, input bit check, input string tag);
      rst = r; soft_rst = s; we = w; re = rd; lfd_state = l; din = d;
      model_step(r, s, w, rd, l, d);
      @(posedge clk);
      #1;
      if (check) compare_model(tag);
   endtask

   typedef struct {
      bit       r, s, w, rd, l;
      bit [7:0] d;
      bit [7:0] e_dout;
      bit       e_empty, e_full, e_done;
   } vec_t;

   vec_t vt[17];

   initial begin
      rst = 1'b0; soft_rst = 1'b0; we = 1'b0; re = 1'b0; lfd_state = 1'b0; din = 8'h00;
      saw_ff = 1'b0;

      //           r  s  w  rd l  din    dout   emp full done
      vt[0]  = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0};
      vt[0].r = 1'b0;
      vt[1]  = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0};
      vt[2]  = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0};
      vt[3]  = '{1, 0, 1, 0, 1, 8'h0D, 8'h00, 0, 0, 0};
      vt[4]  = '{1, 0, 1, 0, 0, 8'hA1, 8'h00, 0, 0, 0};
      vt[5]  = '{1, 0, 1, 0, 0, 8'hA2, 8'h00, 0, 0, 0};
      vt[6]  = '{1, 0, 1, 0, 0, 8'hA3, 8'h00, 0, 0, 0};
      vt[7]  = '{1, 0, 1, 0, 0, 8'h5C, 8'h00, 0, 0, 0};
      vt[8]  = '{1, 0, 0, 1, 0, 8'h00, 8'h0D, 0, 0, 0};
      vt[9]  = '{1, 0, 0, 1, 0, 8'h00, 8'hA1, 0, 0, 0};
      vt[10] = '{1, 0, 0, 1, 0, 8'h00, 8'hA2, 0, 0, 0};
      vt[11] = '{1, 0, 0, 1, 0, 8'h00, 8'hA3, 0, 0, 0};
      vt[12] = '{1, 0, 0, 1, 0, 8'h00, 8'h5C, 1, 0, 1};
      vt[13] = '{1, 0, 0, 0, 0, 8'h00, 8'h5C, 1, 0, 0};
      vt[14] = '{1, 0, 0, 1, 0, 8'h00, 8'h5C, 1, 0, 0};
      vt[15] = '{1, 0, 1, 1, 0, 8'h33, 8'h5C, 0, 0, 0};
      vt[16] = '{1, 0, 0, 1, 0, 8'h00, 8'h33, 1, 0, 0};

      // Directed table: reset, idle, single packet, empty-side corner cases
      for (int i = 0; i < 17; i++) begin
         cyc(vt[i].r, vt[i].s, vt[i].w, vt[i].rd, vt[i].l, vt[i].d, 1'b0, "vec");
         chk($sformatf("vec%0d.dout", i),  int'(dout),        int'(vt[i].e_dout));
         chk($sformatf("vec%0d.empty", i), int'(empty),       int'(vt[i].e_empty));
         chk($sformatf("vec%0d.full", i),  int'(full),        int'(vt[i].e_full));
         chk($sformatf("vec%0d.done", i),  int'(rd_pkt_done), int'(vt[i].e_done));
      end

      // Fill to 16, overflow with 0xFF, then read+write at full, then drain
      cyc(1, 1, 0, 0, 0, 8'h00, 1'b1, "fill_flush");
      for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0, 0, 8'(i * 7 + 1), 1'b1, "fill");
      chk("fill.full_at16", int'(full), 1);
      cyc(1, 0, 1, 0, 0, 8'hFF, 1'b1, "overflow");
`ifdef ROUTER_FIFO_ERR_FLAG_EN
      chk("overflow.err", int'(err), 1);
`endif
      cyc(1, 0, 1, 1, 0, 8'hEE, 1'b1, "rw_full");
      chk("rw_full.first_byte", int'(dout), 1);
      while (mq.size() > 0) cyc(1, 0, 0, 1, 0, 8'h00, 1'b1, "drain");
      chk("drain.no_ff", int'(saw_ff), 0);
      chk("drain.empty", int'(empty), 1);

      // Wrap-around: hold occupancy at 8 through 40 read/write pairs
      cyc(1, 1, 0, 0, 0, 8'h00, 1'b1, "wrap_flush");
      for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0, 8'($urandom_range(0, 254)), 1'b1, "wrap_pre");
      for (int i = 0; i < 40; i++) cyc(1, 0, 1, 1, 0, 8'($urandom_range(0, 254)), 1'b1, "wrap");
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0, 8'h00, 1'b1, "wrap_drain");

      // Soft reset in the middle of a packet discards it and blocks the same-cycle write
      cyc(1, 0, 1, 0, 1, 8'h09, 1'b1, "sr_hdr");
      cyc(1, 0, 1, 0, 0, 8'h11, 1'b1, "sr_p0");
      cyc(1, 0, 1, 0, 0, 8'h22, 1'b1, "sr_p1");
      cyc(1, 0, 0, 1, 0, 8'h00, 1'b1, "sr_rd");
      chk("sr_rd.hdr", int'(dout), 8'h09);
      cyc(1, 1, 1, 1, 0, 8'h77, 1'b1, "sr_pulse");
      chk("sr_pulse.dout", int'(dout), 0);
      chk("sr_pulse.empty", int'(empty), 1);
      cyc(1, 0, 0, 0, 0, 8'h00, 1'b1, "sr_after");
      cyc(1, 0, 0, 1, 0, 8'h00, 1'b1, "sr_rd_empty");
      chk("sr_after.not_stored", int'(dout), 0);

      // Random traffic, including headers with random lengths and occasional flushes
      for (int i = 0; i < 400; i++) begin
         cyc(1, ($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 55),
             ($urandom_range(0, 99) < 50), ($urandom_range(0, 5) == 0),
             8'($urandom_range(0, 255)), 1'b1, "rand");
      end
      cyc(0, 0, 0, 0, 0, 8'h00, 1'b1, "final_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
